// File: rtl/reg_write_arbiter_if.sv
// rtl/reg_write_arbiter_if.sv - requester and register-bank write-port bundle for reg_write_arbiter
interface reg_write_arbiter_if #(
   parameter int NREQ   = 4,
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
);
   logic [NREQ-1:0]        req;
   logic [NREQ*ADDR_W-1:0] wr_addr_in;
   logic [NREQ*DATA_W-1:0] wr_data_in;
   logic [NREQ-1:0]        gnt;
   logic                   rf_we;
   logic [ADDR_W-1:0]      rf_addr;
   logic [DATA_W-1:0]      rf_data;
   logic                   busy;

   modport master (
      output req, wr_addr_in, wr_data_in,
      input  gnt, rf_we, rf_addr, rf_data, busy
   );

   modport slave (
      input  req, wr_addr_in, wr_data_in,
      output gnt, rf_we, rf_addr, rf_data, busy
   );
endinterface

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin arbiter for the register bank's single write port
// Define REG_WR_ARB_FIXED_PRIO_EN for lowest-index-wins priority with no rotating pointer.
module reg_write_arbiter #(
   parameter int NREQ        = 4,
   parameter int ADDR_W      = 3,
   parameter int DATA_W      = 8,
   parameter int ZERO_REG_RO = 1
) (
   input  logic               clk,
   input  logic               rst,
   reg_write_arbiter_if.slave bus
);
   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [PTR_W:0]   NREQ_C = (PTR_W+1)'(NREQ);
   localparam logic [PTR_W-1:0] LAST_C = PTR_W'(NREQ-1);

   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic              rf_we_q, rf_we_d;
   logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
   logic [DATA_W-1:0] rf_data_q, rf_data_d;
   logic [NREQ-1:0]   mreq;
   logic [PTR_W-1:0]  base;
   logic [PTR_W:0]    cand;
   logic              win_found;
   logic [PTR_W-1:0]  win_idx;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_data;

   // A source whose grant is showing cannot win again while it reacts.
   assign mreq     = bus.req & ~gnt_q;
   assign bus.busy = |mreq;

`ifdef REG_WR_ARB_FIXED_PRIO_EN
   assign base = '0;
`else
   logic [PTR_W-1:0] ptr_q, ptr_d;

   assign base = ptr_q;

   always_comb begin
      ptr_d = ptr_q;
      if (win_found) begin
         ptr_d = (win_idx == LAST_C) ? '0 : win_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, base} + (PTR_W+1)'(k);
         if (cand >= NREQ_C) begin
            cand = cand - NREQ_C;
         end
         if (!win_found && mreq[cand[PTR_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[PTR_W-1:0];
         end
      end
   end

   assign win_addr = bus.wr_addr_in[win_idx*ADDR_W +: ADDR_W];
   assign win_data = bus.wr_data_in[win_idx*DATA_W +: DATA_W];

   always_comb begin
      gnt_d = '0;
      if (win_found) begin
         gnt_d[win_idx] = 1'b1;
      end
      rf_we_d   = win_found && !((ZERO_REG_RO != 0) && (win_addr == '0));
      rf_addr_d = win_found ? win_addr : rf_addr_q;
      rf_data_d = win_found ? win_data : rf_data_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_q     <= '0;
         rf_we_q   <= 1'b0;
         rf_addr_q <= '0;
         rf_data_q <= '0;
      end else begin
         gnt_q     <= gnt_d;
         rf_we_q   <= rf_we_d;
         rf_addr_q <= rf_addr_d;
         rf_data_q <= rf_data_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.rf_we   = rf_we_q;
   assign bus.rf_addr = rf_addr_q;
   assign bus.rf_data = rf_data_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - randomized and directed bench for reg_write_arbiter against an index-level model
module tb_reg_write_arbiter;
   localparam int NREQ   = 4;
   localparam int ADDR_W = 3;
   localparam int DATA_W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   reg_write_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();
   reg_write_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();

   reg_write_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZERO_REG_RO(1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1));
   reg_write_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZERO_REG_RO(0)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0));

   logic [NREQ-1:0]   req;
   logic [ADDR_W-1:0] a [NREQ];
   logic [DATA_W-1:0] d [NREQ];

   // Model: winning index shown this cycle (-1 for none), next-priority index, registered outputs.
   int                win_m;
   int                ptr_m;
   logic [ADDR_W-1:0] exp_addr;
   logic [DATA_W-1:0] exp_data;
   logic              exp_we1, exp_we0;
   bit                known;

   int passed = 0;
   int total  = 0;
   int cnt [NREQ];
   int prev_win;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         bus1.wr_addr_in[i*ADDR_W +: ADDR_W] = a[i];
         bus1.wr_data_in[i*DATA_W +: DATA_W] = d[i];
         bus0.wr_addr_in[i*ADDR_W +: ADDR_W] = a[i];
         bus0.wr_data_in[i*DATA_W +: DATA_W] = d[i];
      end
      bus1.req = req;
      bus0.req = req;
   endtask

   function automatic logic [NREQ-1:0] exp_gnt();
      return (win_m >= 0) ? NREQ'(1 << win_m) : '0;
   endfunction

   function automatic int pick(input logic [NREQ-1:0] m, input int start);
      for (int k = 0; k < NREQ; k++) begin
         if (m[(start + k) % NREQ]) return (start + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic cycle();
      logic [NREQ-1:0] m;
      int w;
      drive();
      #1;
      m = req & ~exp_gnt();
      if (known) begin
         chk("busy1", 32'(bus1.busy), 32'(|m));
         chk("busy0", 32'(bus0.busy), 32'(|m));
      end
`ifdef REG_WR_ARB_FIXED_PRIO_EN
      w = pick(m, 0);
`else
      w = pick(m, ptr_m);
`endif
      @(posedge clk);
      if (rst) begin
         win_m = -1; ptr_m = 0; exp_addr = '0; exp_data = '0;
         exp_we1 = 1'b0; exp_we0 = 1'b0; known = 1'b1;
      end else if (w >= 0) begin
         win_m = w; ptr_m = (w + 1) % NREQ; exp_addr = a[w]; exp_data = d[w];
         exp_we1 = (a[w] != '0); exp_we0 = 1'b1;
      end else begin
         win_m = -1; exp_we1 = 1'b0; exp_we0 = 1'b0;
      end
      @(negedge clk);
      chk("gnt1",  32'(bus1.gnt),     32'(exp_gnt()));
      chk("gnt0",  32'(bus0.gnt),     32'(exp_gnt()));
      chk("we1",   32'(bus1.rf_we),   32'(exp_we1));
      chk("we0",   32'(bus0.rf_we),   32'(exp_we0));
      chk("addr1", 32'(bus1.rf_addr), 32'(exp_addr));
      chk("addr0", 32'(bus0.rf_addr), 32'(exp_addr));
      chk("data1", 32'(bus1.rf_data), 32'(exp_data));
      chk("data0", 32'(bus0.rf_data), 32'(exp_data));
   endtask

   initial begin
      win_m = -1; ptr_m = 0; exp_addr = '0; exp_data = '0;
      exp_we1 = 1'b0; exp_we0 = 1'b0; known = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         a[i] = ADDR_W'($urandom); d[i] = DATA_W'($urandom); cnt[i] = 0;
      end

      // Reset held with all sources requesting.
      rst = 1'b1; req = 4'b1111;
      for (int c = 0; c < 3; c++) begin
         cycle();
         chk("rst_gnt",  32'(bus1.gnt),     32'h0);
         chk("rst_we",   32'(bus1.rf_we),   32'h0);
         chk("rst_addr", 32'(bus1.rf_addr), 32'h0);
         chk("rst_data", 32'(bus1.rf_data), 32'h0);
      end
      rst = 1'b0;
      cycle();
      chk("first_gnt", 32'(bus1.gnt), 32'h1);

      // Single write from source 2, then it drops.
      req = 4'b0100; a[2] = 3'd5; d[2] = 8'hA7;
      cycle();
      chk("single_gnt",  32'(bus1.gnt),     32'h4);
      chk("single_we",   32'(bus1.rf_we),   32'h1);
      chk("single_addr", 32'(bus1.rf_addr), 32'h5);
      chk("single_data", 32'(bus1.rf_data), 32'hA7);
      req = 4'b0000;
      cycle();
      chk("single_nogrant", 32'(bus1.gnt), 32'h0);

      // Fairness from a fresh reset with all sources held.
      rst = 1'b1;
      cycle();
      rst = 1'b0; req = 4'b1111;
      for (int c = 0; c < 100; c++) begin
         if (win_m >= 0) d[win_m] = DATA_W'($urandom);
         cycle();
         if (win_m >= 0) cnt[win_m]++;
         chk("fair_nogap", 32'(win_m >= 0), 32'h1);
`ifdef REG_WR_ARB_FIXED_PRIO_EN
         if (c < 4) chk("fair_seq", 32'(bus1.gnt), 32'(4'b0001 << (c % 2)));
`else
         if (c < 4) chk("fair_seq", 32'(bus1.gnt), 32'(4'b0001 << c));
`endif
      end
`ifdef REG_WR_ARB_FIXED_PRIO_EN
      chk("fair_cnt0", 32'(cnt[0]), 32'd50);
      chk("fair_cnt1", 32'(cnt[1]), 32'd50);
      chk("fair_cnt2", 32'(cnt[2]), 32'd0);
      chk("fair_cnt3", 32'(cnt[3]), 32'd0);
`else
      chk("fair_cnt0", 32'(cnt[0]), 32'd25);
      chk("fair_cnt1", 32'(cnt[1]), 32'd25);
      chk("fair_cnt2", 32'(cnt[2]), 32'd25);
      chk("fair_cnt3", 32'(cnt[3]), 32'd25);
`endif

      // Two persistent sources must alternate because of the grant mask.
`ifdef REG_WR_ARB_FIXED_PRIO_EN
      req = 4'b1010;
`else
      req = 4'b1001;
`endif
      for (int c = 0; c < 20; c++) begin
         prev_win = win_m;
         if (win_m >= 0) d[win_m] = DATA_W'($urandom);
         cycle();
         if (c == 0) begin
`ifdef REG_WR_ARB_FIXED_PRIO_EN
            chk("wrap_first", 32'(bus1.gnt), 32'h8);
`else
            chk("wrap_first", 32'(bus1.gnt), 32'h1);
`endif
         end
         chk("wrap_alt", 32'((win_m >= 0) && (win_m != prev_win)), 32'h1);
      end

      // Address 0 is granted but only written when the zero register is writable.
      req = 4'b0000;
      cycle();
      req = 4'b0010; a[1] = 3'd0; d[1] = 8'hFF;
      cycle();
      chk("zero_gnt", 32'(bus1.gnt),   32'h2);
      chk("zero_we1", 32'(bus1.rf_we), 32'h0);
      chk("zero_we0", 32'(bus0.rf_we), 32'h1);
      chk("zero_dat", 32'(bus0.rf_data), 32'hFF);
      req = 4'b0000;
      cycle();

      // Random traffic obeying the requester protocol, with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (req[i]) begin
               if (win_m == i) begin
                  if ($urandom_range(0, 1) == 1) begin
                     a[i] = ADDR_W'($urandom); d[i] = DATA_W'($urandom);
                  end else begin
                     req[i] = 1'b0;
                  end
               end
            end else if ($urandom_range(0, 2) == 0) begin
               req[i] = 1'b1; a[i] = ADDR_W'($urandom); d[i] = DATA_W'($urandom);
            end
         end
         rst = ($urandom_range(0, 199) == 0);
         cycle();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
